// File: rtl/core_trap_sequencer_if.sv
// Fetch redirect handshake between the trap sequencer and the front end.
interface core_trap_sequencer_if;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/core_trap_sequencer.sv
// Trap/xRET sequencer: arbitrates trap sources at instruction boundaries,
// then walks the EPC/CAUSE/TVAL/STATUS CSR updates and the fetch redirect.
package core_trap_pkg;
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [4:0] {
        EXC_INSN_MISALIGNED = 5'd0,
        EXC_INSN_FAULT      = 5'd1,
        EXC_ILLEGAL_INSN    = 5'd2,
        EXC_BREAKPOINT      = 5'd3,
        EXC_LOAD_FAULT      = 5'd5,
        EXC_STORE_FAULT     = 5'd7,
        EXC_ECALL_UMODE     = 5'd8,
        EXC_ECALL_SMODE     = 5'd9,
        EXC_ECALL_MMODE     = 5'd11,
        EXC_CUSTOM_24       = 5'd24
    } exception_e;

    typedef enum logic [4:0] {
        IRQ_S_SOFT     = 5'd1,
        IRQ_M_SOFT     = 5'd3,
        IRQ_S_TIMER    = 5'd5,
        IRQ_M_TIMER    = 5'd7,
        IRQ_S_EXTERNAL = 5'd9,
        IRQ_M_EXTERNAL = 5'd11
    } interrupt_e;
endpackage

module core_trap_sequencer
    import core_trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_check,
    input  logic        exception_valid,
    input  exception_e  exception_cause,
    input  logic [31:0] exception_value,
    input  logic        m_interrupt_valid,
    input  interrupt_e  m_interrupt_cause,
    input  logic        s_interrupt_valid,
    input  interrupt_e  s_interrupt_cause,
    input  logic        mret,
    input  logic        sret,
    input  logic [31:0] pc,
    input  priv_e       priv,
    input  logic [15:0] cfg_medeleg,
    input  logic [15:0] cfg_mideleg,
    input  logic [31:0] cfg_mtvec,
    input  logic [31:0] cfg_stvec,
    input  logic [31:0] cfg_mepc,
    input  logic [31:0] cfg_sepc,
    core_trap_sequencer_if.master redirect,
    output logic        busy,
    output priv_e       csr_target,
    output logic        csr_epc_we,
    output logic        csr_cause_we,
    output logic        csr_tval_we,
    output logic [31:0] csr_wdata,
    output logic        csr_status_trap,
    output logic        csr_status_ret
);
    typedef enum logic [2:0] {
        IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, STATUS, JUMP
    } state_e;

    state_e      state_q, state_d;
    priv_e       target_q;
    logic        is_irq_q, is_ret_q, ret_m_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q, tval_q, rpc_q;

    logic take_m, take_s, take_e, take_mret, take_sret;
    logic win_trap, win_ret, win_irq, win_ret_m, can_deleg;
    logic [4:0]  win_code;
    logic [15:0] deleg_mask;
    priv_e       win_target;
    logic [31:0] tvec, trap_pc;

    // One-hot priority so the decoder below really is unique.
    assign take_m    = m_interrupt_valid;
    assign take_s    = s_interrupt_valid & ~m_interrupt_valid;
    assign take_e    = exception_valid & ~m_interrupt_valid
                     & ~s_interrupt_valid;
    assign take_mret = mret & ~m_interrupt_valid & ~s_interrupt_valid
                     & ~exception_valid;
    assign take_sret = sret & ~mret & ~m_interrupt_valid
                     & ~s_interrupt_valid & ~exception_valid;

    always_comb begin
        win_trap  = 1'b0;
        win_ret   = 1'b0;
        win_irq   = 1'b0;
        win_ret_m = 1'b0;
        win_code  = 5'd0;
        unique case (1'b1)
            take_m: begin
                win_trap = 1'b1;
                win_irq  = 1'b1;
                win_code = m_interrupt_cause;
            end
            take_s: begin
                win_trap = 1'b1;
                win_irq  = 1'b1;
                win_code = s_interrupt_cause;
            end
            take_e: begin
                win_trap = 1'b1;
                win_code = exception_cause;
            end
            take_mret: begin
                win_ret   = 1'b1;
                win_ret_m = 1'b1;
            end
            take_sret: win_ret = 1'b1;
            default: ;
        endcase
    end

    assign deleg_mask = win_irq ? cfg_mideleg : cfg_medeleg;
    assign can_deleg  = (priv != PRIV_M) && !win_code[4]
                      && deleg_mask[win_code[3:0]];
    assign win_target = win_ret ? (win_ret_m ? PRIV_M : PRIV_S)
                      : (can_deleg ? PRIV_S : PRIV_M);

    // Vectored mode only offsets interrupts; exceptions use the base.
    assign tvec    = (target_q == PRIV_S) ? cfg_stvec : cfg_mtvec;
    assign trap_pc = {tvec[31:2], 2'b00}
                   + ((tvec[1:0] == 2'b01 && is_irq_q)
                      ? {25'd0, code_q, 2'b00} : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trap_check && win_trap)     state_d = SAVE_EPC;
                else if (trap_check && win_ret) state_d = STATUS;
            end
            SAVE_EPC:   state_d = SAVE_CAUSE;
            SAVE_CAUSE: state_d = SAVE_TVAL;
            SAVE_TVAL:  state_d = STATUS;
            STATUS:     state_d = JUMP;
            JUMP: if (redirect.redirect_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= PRIV_M;
            is_irq_q <= 1'b0;
            is_ret_q <= 1'b0;
            ret_m_q  <= 1'b0;
            code_q   <= 5'd0;
            epc_q    <= 32'd0;
            tval_q   <= 32'd0;
            rpc_q    <= 32'd0;
        end else begin
            if (state_q == IDLE && trap_check && (win_trap || win_ret)) begin
                target_q <= win_target;
                is_irq_q <= win_irq;
                is_ret_q <= win_ret;
                ret_m_q  <= win_ret_m;
                code_q   <= win_code;
                epc_q    <= pc;
                tval_q   <= win_irq ? 32'd0 : exception_value;
            end
            if (state_q == STATUS)
                rpc_q <= is_ret_q ? (ret_m_q ? cfg_mepc : cfg_sepc)
                                  : trap_pc;
        end
    end

    always_comb begin
        csr_epc_we      = 1'b0;
        csr_cause_we    = 1'b0;
        csr_tval_we     = 1'b0;
        csr_wdata       = 32'd0;
        csr_status_trap = 1'b0;
        csr_status_ret  = 1'b0;
        redirect.redirect_valid = 1'b0;
        unique case (state_q)
            SAVE_EPC: begin
                csr_epc_we = 1'b1;
                csr_wdata  = epc_q;
            end
            SAVE_CAUSE: begin
                csr_cause_we = 1'b1;
                csr_wdata    = {is_irq_q, 26'd0, code_q};
            end
            SAVE_TVAL: begin
                csr_tval_we = 1'b1;
                csr_wdata   = tval_q;
            end
            STATUS: begin
                csr_status_trap = ~is_ret_q;
                csr_status_ret  = is_ret_q;
            end
            JUMP: redirect.redirect_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy                 = (state_q != IDLE);
    assign csr_target           = target_q;
    assign redirect.redirect_pc = rpc_q;
endmodule
